// File: rtl/pipe_pkg.sv
// Shared definitions for the operand-forwarding pipeline register: default widths,
// the hard-wired zero register id and the forwarding-source record.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int RA_W_DEF   = 5;
    localparam int SIDE_W_DEF = 64;

    // Writes to register 0 are discarded architecturally, so it is never a forwarding target.
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic                  we;
        logic [RA_W_DEF-1:0]   dst;
        logic [DATA_W_DEF-1:0] data;
        logic                  pending;
    } fwd_src_t;

endpackage

// File: rtl/pipe_fwd_reg_if.sv
// Upstream/downstream handshake bundle of pipe_fwd_reg; master drives entries in and
// takes results out, slave is the pipeline register itself.
interface pipe_fwd_reg_if import pipe_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int SIDE_W = SIDE_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [SIDE_W-1:0] in_side;
    logic [RA_W-1:0]   in_rs_id;
    logic [RA_W-1:0]   in_rt_id;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic              in_uses_rs;
    logic              in_uses_rt;

    logic              out_valid;
    logic              out_ready;
    logic [SIDE_W-1:0] out_side;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;

    modport master (
        output in_valid, in_side, in_rs_id, in_rt_id, in_rs_data, in_rt_data,
               in_uses_rs, in_uses_rt, out_ready,
        input  in_ready, out_valid, out_side, out_rs_data, out_rt_data
    );

    modport slave (
        input  in_valid, in_side, in_rs_id, in_rt_id, in_rs_data, in_rt_data,
               in_uses_rs, in_uses_rt, out_ready,
        output in_ready, out_valid, out_side, out_rs_data, out_rt_data
    );

endinterface

// File: rtl/pipe_fwd_sel.sv
// Per-operand forwarding selector: priority match over the forwarding sources (index 0
// wins), operand mux, and the stall/refresh decisions for the held operand.
module pipe_fwd_sel import pipe_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int N_FWD  = 2,
    parameter bit BYPASS = 1'b0
) (
    input  logic [RA_W-1:0]         id,
    input  logic                    uses,
    input  logic [DATA_W-1:0]       stored,
    input  logic [N_FWD-1:0]        fwd_we,
    input  logic [N_FWD*RA_W-1:0]   fwd_dst,
    input  logic [N_FWD*DATA_W-1:0] fwd_data,
    input  logic [N_FWD-1:0]        fwd_pending,
    output logic [DATA_W-1:0]       data_out,
    output logic                    stall,
    output logic                    refresh
);

    logic [N_FWD-1:0]  match;
    logic              hit;
    logic              sel_pending;
    logic [DATA_W-1:0] sel_data;

    genvar gi;
    generate
        for (gi = 0; gi < N_FWD; gi++) begin : g_match
            assign match[gi] = fwd_we[gi] && uses
                            && (fwd_dst[gi*RA_W +: RA_W] != RA_W'(REG_ZERO))
                            && (fwd_dst[gi*RA_W +: RA_W] == id);
        end
    endgenerate

    // Walk from oldest to youngest so the lowest matching index is left selected.
    always_comb begin
        hit         = 1'b0;
        sel_pending = 1'b0;
        sel_data    = '0;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit         = 1'b1;
                sel_pending = fwd_pending[i];
                sel_data    = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Without bypass any in-flight writer to this operand blocks until it retires.
    assign data_out = (BYPASS && hit) ? sel_data : stored;
    assign stall    = hit && (sel_pending || !BYPASS);
    assign refresh  = BYPASS && hit && !sel_pending;

endmodule

// File: rtl/pipe_fwd_reg.sv
// One-entry valid/ready pipeline register with operand forwarding and hazard stall.
// Define PIPE_FWD_BYPASS_EN to enable forwarding; otherwise the stage interlocks.
module pipe_fwd_reg import pipe_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int SIDE_W = SIDE_W_DEF,
    parameter int N_FWD  = 2
) (
    input  logic                    sys_clk,
    input  logic                    rst,
    pipe_fwd_reg_if.slave           bus,
    input  logic                    flush,
    input  logic [N_FWD-1:0]        fwd_we,
    input  logic [N_FWD*RA_W-1:0]   fwd_dst,
    input  logic [N_FWD*DATA_W-1:0] fwd_data,
    input  logic [N_FWD-1:0]        fwd_pending,
    output logic [15:0]             hz_cnt
);

`ifdef PIPE_FWD_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic              full_reg;
    logic [SIDE_W-1:0] side_reg;
    logic [RA_W-1:0]   rs_id_reg;
    logic [RA_W-1:0]   rt_id_reg;
    logic              uses_rs_reg;
    logic              uses_rt_reg;
    logic [DATA_W-1:0] rs_data_reg;
    logic [DATA_W-1:0] rt_data_reg;
    logic [15:0]       hz_cnt_reg;

    logic [DATA_W-1:0] rs_sel_data;
    logic [DATA_W-1:0] rt_sel_data;
    logic              rs_stall;
    logic              rt_stall;
    logic              rs_refresh;
    logic              rt_refresh;
    logic              hazard;
    logic              fire;
    logic              accept;

    pipe_fwd_sel #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .N_FWD  (N_FWD),
        .BYPASS (BYPASS_EN)
    ) u_sel_rs (
        .id          (rs_id_reg),
        .uses        (uses_rs_reg),
        .stored      (rs_data_reg),
        .fwd_we      (fwd_we),
        .fwd_dst     (fwd_dst),
        .fwd_data    (fwd_data),
        .fwd_pending (fwd_pending),
        .data_out    (rs_sel_data),
        .stall       (rs_stall),
        .refresh     (rs_refresh)
    );

    pipe_fwd_sel #(
        .DATA_W (DATA_W),
        .RA_W   (RA_W),
        .N_FWD  (N_FWD),
        .BYPASS (BYPASS_EN)
    ) u_sel_rt (
        .id          (rt_id_reg),
        .uses        (uses_rt_reg),
        .stored      (rt_data_reg),
        .fwd_we      (fwd_we),
        .fwd_dst     (fwd_dst),
        .fwd_data    (fwd_data),
        .fwd_pending (fwd_pending),
        .data_out    (rt_sel_data),
        .stall       (rt_stall),
        .refresh     (rt_refresh)
    );

    assign hazard          = full_reg && (rs_stall || rt_stall);
    assign bus.out_valid   = full_reg && !hazard && !rst;
    assign fire            = bus.out_valid && bus.out_ready;
    // Flush frees the slot for next cycle, so upstream is never back-pressured by it.
    assign bus.in_ready    = rst || flush || !full_reg || fire;
    assign accept          = bus.in_valid && bus.in_ready && !flush;
    assign bus.out_side    = side_reg;
    assign bus.out_rs_data = rs_sel_data;
    assign bus.out_rt_data = rt_sel_data;
    assign hz_cnt          = hz_cnt_reg;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            full_reg    <= 1'b0;
            side_reg    <= '0;
            rs_id_reg   <= '0;
            rt_id_reg   <= '0;
            uses_rs_reg <= 1'b0;
            uses_rt_reg <= 1'b0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            hz_cnt_reg  <= '0;
        end else begin
            if (flush) begin
                full_reg <= 1'b0;
            end else if (accept) begin
                full_reg    <= 1'b1;
                side_reg    <= bus.in_side;
                rs_id_reg   <= bus.in_rs_id;
                rt_id_reg   <= bus.in_rt_id;
                uses_rs_reg <= bus.in_uses_rs;
                uses_rt_reg <= bus.in_uses_rt;
                rs_data_reg <= bus.in_rs_data;
                rt_data_reg <= bus.in_rt_data;
            end else if (fire) begin
                full_reg <= 1'b0;
            end else if (full_reg) begin
                // Capture forwarded values while held so a writer retiring mid-stall is not lost.
                if (rs_refresh) begin
                    rs_data_reg <= rs_sel_data;
                end
                if (rt_refresh) begin
                    rt_data_reg <= rt_sel_data;
                end
            end

            if (hazard && (hz_cnt_reg != 16'hFFFF)) begin
                hz_cnt_reg <= hz_cnt_reg + 16'd1;
            end
        end
    end

endmodule
